// File: rtl/bit_serial_adder_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bit_serial_adder_ctrl_pkg
// Brief    : State encoding shared by the bit-serial adder sequencer.
// Revision : 1.0
// ============================================================================
package bit_serial_adder_ctrl_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_RUN  = S_RUN,
    ST_DONE = S_DONE
  } state_t;

endpackage : bit_serial_adder_ctrl_pkg
`default_nettype wire

// File: rtl/bit_serial_adder_ctrl_full_addr.sv
`default_nettype none
// ============================================================================
// Module   : half_addr / full_addr
// Brief    : One-bit full adder built from two half adders and an OR gate.
// Revision : 1.0
// ============================================================================
module half_addr (
  input  logic i_a,
  input  logic i_b,
  output logic o_sum,
  output logic o_carry
);

  assign o_sum   = i_a ^ i_b;
  assign o_carry = i_a & i_b;

endmodule : half_addr

module full_addr (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic cout,
  output logic sum
);

  logic w_s1;
  logic w_c1;
  logic w_c2;

  half_addr u_ha0 (
    .i_a     (a),
    .i_b     (b),
    .o_sum   (w_s1),
    .o_carry (w_c1)
  );

  half_addr u_ha1 (
    .i_a     (w_s1),
    .i_b     (cin),
    .o_sum   (sum),
    .o_carry (w_c2)
  );

  // Both carries can never be high together, so OR equals the majority.
  assign cout = w_c1 | w_c2;

endmodule : full_addr
`default_nettype wire

// File: rtl/bit_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bit_serial_adder_ctrl
// Brief    : Adds two N-bit operands one bit per cycle through a shared
//            full-adder cell, with a start/busy/done handshake.
// Revision : 1.0
// ============================================================================
module bit_serial_adder_ctrl #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         cout
);

  import bit_serial_adder_ctrl_pkg::*;

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] c_last_cnt = CW'(N - 1);

  state_t          r_state;
  logic [N-1:0]    r_opa;
  logic [N-1:0]    r_opb;
  // Holds result bits [N-1:1]; bit 0 falls out on the final shift anyway.
  logic [N-2:0]    r_res;
  logic            r_carry;
  logic [CW-1:0]   r_cnt;
  logic            r_busy;
  logic            r_done;
  logic [N-1:0]    r_sum;
  logic            r_cout;

  logic            w_s;
  logic            w_c;
  logic [N-1:0]    w_res_full;

  full_addr u_fa (
    .a    (r_opa[0]),
    .b    (r_opb[0]),
    .cin  (r_carry),
    .cout (w_c),
    .sum  (w_s)
  );

  assign w_res_full = {w_s, r_res};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_opa   <= '0;
      r_opb   <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_opa   <= a;
            r_opb   <= b;
            r_carry <= cin;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_state <= ST_RUN;
          end else begin
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_res   <= w_res_full[N-1:1];
          r_opa   <= {1'b0, r_opa[N-1:1]};
          r_opb   <= {1'b0, r_opb[N-1:1]};
          r_carry <= w_c;
          r_cnt   <= r_cnt + CW'(1);
          if (r_cnt == c_last_cnt) begin
            r_sum   <= w_res_full;
            r_cout  <= w_c;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule : bit_serial_adder_ctrl
`default_nettype wire

// File: tb/tb_bit_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bit_serial_adder_ctrl
// Brief    : Directed and randomized checks against an arithmetic model.
// Revision : 1.0
// ============================================================================
module tb_bit_serial_adder_ctrl;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [N-1:0] sum;
  logic         cout;

  int n_vec = 0;
  int n_err = 0;

  logic [N-1:0] held_sum;
  logic         held_cout;
  logic [N:0]   pend;

  bit_serial_adder_ctrl #(.N(N)) u_dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge; the reference result is plain addition.
  task automatic issue(input logic [N-1:0] ia, input logic [N-1:0] ib, input logic ic);
    a     = ia;
    b     = ib;
    cin   = ic;
    start = 1'b1;
    pend  = {1'b0, ia} + {1'b0, ib} + {{N{1'b0}}, ic};
    tick();
    start = 1'b0;
    a     = N'($urandom);
    b     = N'($urandom);
    cin   = 1'($urandom);
  endtask

  // Walk the N busy cycles, then land on the done cycle without leaving it.
  task automatic run_body(input int pulse_at);
    for (int i = 0; i < N; i++) begin
      check("busy_run", {63'd0, busy}, 64'd1);
      check("done_run", {63'd0, done}, 64'd0);
      check("sum_hold", {56'd0, sum}, {56'd0, held_sum});
      check("cout_hold", {63'd0, cout}, {63'd0, held_cout});
      if (i == pulse_at) begin
        start = 1'b1;
        a     = 8'hAA;
        b     = 8'h55;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    check("done_pulse", {63'd0, done}, 64'd1);
    check("busy_done", {63'd0, busy}, 64'd0);
    check("sum_result", {56'd0, sum}, {56'd0, pend[N-1:0]});
    check("cout_result", {63'd0, cout}, {63'd0, pend[N]});
    held_sum  = pend[N-1:0];
    held_cout = pend[N];
  endtask

  task automatic to_idle();
    start = 1'b0;
    tick();
    check("done_clear", {63'd0, done}, 64'd0);
    check("busy_idle", {63'd0, busy}, 64'd0);
    check("sum_idle", {56'd0, sum}, {56'd0, held_sum});
    check("cout_idle", {63'd0, cout}, {63'd0, held_cout});
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    held_sum  = '0;
    held_cout = 1'b0;
    pend      = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_sum", {56'd0, sum}, 64'h00);
    check("rst_cout", {63'd0, cout}, 64'd0);
    tick();

    issue(8'h3C, 8'h5A, 1'b0);
    run_body(-1);
    check("basic_sum", {56'd0, sum}, 64'h96);
    to_idle();

    issue(8'hFF, 8'h01, 1'b0);
    run_body(-1);
    check("wrap_sum", {56'd0, sum}, 64'h00);
    check("wrap_cout", {63'd0, cout}, 64'd1);
    to_idle();
    issue(8'hFF, 8'hFF, 1'b1);
    run_body(-1);
    check("max_sum", {56'd0, sum}, 64'hFF);
    check("max_cout", {63'd0, cout}, 64'd1);
    to_idle();

    // A start pulse mid-RUN must neither restart nor queue a second op.
    issue(8'h01, 8'h01, 1'b0);
    run_body(3);
    check("ign_sum", {56'd0, sum}, 64'h02);
    to_idle();
    for (int i = 0; i < N + 3; i++) begin
      check("ign_nodone", {63'd0, done}, 64'd0);
      check("ign_nobusy", {63'd0, busy}, 64'd0);
      check("ign_sum_stable", {56'd0, sum}, 64'h02);
      tick();
    end

    issue(8'h01, 8'h02, 1'b0);
    run_body(-1);
    check("b2b_first", {56'd0, sum}, 64'h03);
    issue(8'h10, 8'h20, 1'b0);
    run_body(-1);
    check("b2b_second", {56'd0, sum}, 64'h30);
    to_idle();

    issue(8'h55, 8'hAA, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check("abort_busy", {63'd0, busy}, 64'd1);
      tick();
    end
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    held_sum  = '0;
    held_cout = 1'b0;
    check("abort_busy_clr", {63'd0, busy}, 64'd0);
    check("abort_sum", {56'd0, sum}, 64'h00);
    check("abort_cout", {63'd0, cout}, 64'd0);
    for (int i = 0; i < N + 2; i++) begin
      check("abort_nodone", {63'd0, done}, 64'd0);
      tick();
    end
    issue(8'h7F, 8'h01, 1'b0);
    run_body(-1);
    check("post_abort_sum", {56'd0, sum}, 64'h80);
    check("post_abort_cout", {63'd0, cout}, 64'd0);
    to_idle();

    rst   = 1'b1;
    start = 1'b1;
    a     = 8'h12;
    b     = 8'h34;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    held_sum  = '0;
    held_cout = 1'b0;
    check("rst_start_busy", {63'd0, busy}, 64'd0);
    check("rst_start_done", {63'd0, done}, 64'd0);
    tick();
    check("rst_start_busy2", {63'd0, busy}, 64'd0);
    check("rst_start_sum", {56'd0, sum}, 64'h00);

    for (int k = 0; k < 40; k++) begin
      issue(N'($urandom), N'($urandom), 1'($urandom));
      run_body(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N - 2)) : -1);
      if ($urandom_range(0, 1) == 0)
        to_idle();
    end
    to_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_bit_serial_adder_ctrl
`default_nettype wire
